// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes non-memory results through and runs load/store
// requests to the D-cache, producing a one-cycle mem_done with writeback data.
module mem_access_stage #(
   parameter int XLEN       = 64,
   parameter int WAIT_LIMIT = 256
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mem_enable,
   input  logic [XLEN-1:0] alu_data_in,
   input  logic [XLEN-1:0] store_data_in,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   output logic            dc_req_valid,
   input  logic            dc_req_ready,
   output logic [XLEN-1:0] dc_req_addr,
   output logic            dc_req_write,
   output logic [XLEN-1:0] dc_req_wdata,
   output logic [7:0]      dc_req_strb,
   input  logic            dc_resp_valid,
   input  logic [XLEN-1:0] dc_resp_rdata,
   output logic [XLEN-1:0] wb_data_out,
   output logic            mem_done,
   output logic            mem_busy,
   output logic            mem_err,
   output logic [1:0]      dbg_state_o
);

   localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [CW-1:0] LIM_M1 = CW'(WAIT_LIMIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] sdata_q, sdata_d;
   logic [2:0]      f3_q, f3_d;
   logic            write_q, write_d;
   logic [XLEN-1:0] wb_q, wb_d;
   logic            err_q, err_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            in_load, in_store, in_bad_f3, in_misal, timeout;
   logic [XLEN-1:0] lane, load_ext;
   logic [7:0]      strb_base;

   assign in_load  = (opcode == 7'b0000011);
   assign in_store = (opcode == 7'b0100011);
   assign timeout  = (WAIT_LIMIT != 0) && (cnt_q == LIM_M1);

   always_comb begin
      in_bad_f3 = 1'b0;
      if (in_load)       in_bad_f3 = (funct3 == 3'b111);
      else if (in_store) in_bad_f3 = funct3[2];
      case (funct3[1:0])
         2'b00:   in_misal = 1'b0;
         2'b01:   in_misal = alu_data_in[0];
         2'b10:   in_misal = |alu_data_in[1:0];
         default: in_misal = |alu_data_in[2:0];
      endcase
      in_misal = in_misal && (in_load || in_store);
   end

   // The cache returns the aligned doubleword; pick out the addressed lane.
   assign lane = dc_resp_rdata >> {addr_q[2:0], 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  load_ext = {{56{lane[7]}},  lane[7:0]};
         3'b001:  load_ext = {{48{lane[15]}}, lane[15:0]};
         3'b010:  load_ext = {{32{lane[31]}}, lane[31:0]};
         3'b011:  load_ext = lane;
         3'b100:  load_ext = {56'd0, lane[7:0]};
         3'b101:  load_ext = {48'd0, lane[15:0]};
         3'b110:  load_ext = {32'd0, lane[31:0]};
         default: load_ext = '0;
      endcase
   end

   always_comb begin
      case (f3_q[1:0])
         2'b00:   strb_base = 8'h01;
         2'b01:   strb_base = 8'h03;
         2'b10:   strb_base = 8'h0F;
         default: strb_base = 8'hFF;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sdata_d = sdata_q;
      f3_d    = f3_q;
      write_d = write_q;
      wb_d    = wb_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (mem_enable) begin
               addr_d  = alu_data_in;
               sdata_d = store_data_in;
               f3_d    = funct3;
               write_d = in_store;
               if (in_bad_f3 || in_misal) begin
                  wb_d    = '0;
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (in_load || in_store) begin
                  cnt_d   = '0;
                  state_d = S_ISSUE;
               end else begin
                  wb_d    = alu_data_in;
                  err_d   = 1'b0;
                  state_d = S_DONE;
               end
            end
         end
         S_ISSUE: begin
            // A handshake on the final allowed cycle still counts as success.
            if (dc_req_ready) begin
               if (write_q) begin
                  wb_d    = '0;
                  err_d   = 1'b0;
                  state_d = S_DONE;
               end else begin
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end
            end else if (timeout) begin
               wb_d    = '0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT: begin
            if (dc_resp_valid) begin
               wb_d    = load_ext;
               err_d   = 1'b0;
               state_d = S_DONE;
            end else if (timeout) begin
               wb_d    = '0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         sdata_q <= '0;
         f3_q    <= '0;
         write_q <= 1'b0;
         wb_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         f3_q    <= f3_d;
         write_q <= write_d;
         wb_q    <= wb_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request outputs decode straight from registered state so reset drops them at once.
   assign dc_req_valid = (state_q == S_ISSUE);
   assign dc_req_addr  = addr_q;
   assign dc_req_write = write_q;
   assign dc_req_wdata = sdata_q << {addr_q[2:0], 3'b000};
   assign dc_req_strb  = write_q ? (strb_base << addr_q[2:0]) : 8'h00;
   assign wb_data_out  = wb_q;
   assign mem_err      = err_q;
   assign mem_done     = (state_q == S_DONE);
   assign mem_busy     = (state_q != S_IDLE);
   assign dbg_state_o  = state_q;

endmodule
